// File: rtl/camera_i2c_cfg_ctrl.sv
// camera_i2c_cfg_ctrl
// SCCB/I2C write sequencer for sensor bring-up. Walks the register LUT from index 0 to
// REG_NUM-1 and writes each {addr_hi, addr_lo, data} entry behind the device write byte.
// A pause follows the software-reset write at SWRST_IDX.
// Optional build macro: CAM_CFG_ACK_CHECK_EN. When it is defined, a NACK makes the
// controller retry the same index, and repeated NACKs on one index end in an error state.
module camera_i2c_cfg_ctrl #(
   parameter int         CLK_FREQ  = 50_000_000,
   parameter int         I2C_FREQ  = 250_000,
   parameter logic [6:0] DEV_ADDR  = 7'h60,
   parameter int         REG_NUM   = 126,
   parameter int         PWR_DLY   = 1_000_000,
   parameter int         SWRST_DLY = 250_000,
   parameter int         SWRST_IDX = 1,
   parameter int         MAX_RETRY = 3
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cfg_start,
   input  logic [23:0] lut_data,
   output logic [8:0]  reg_index,
   output logic        scl,
   inout  wire         sda,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err
);

   localparam int QDIV    = CLK_FREQ / (4 * I2C_FREQ);
   localparam int GAP_DLY = 4 * QDIV;
   localparam int MAX_A   = (PWR_DLY > SWRST_DLY) ? PWR_DLY : SWRST_DLY;
   localparam int MAX_DLY = (MAX_A > GAP_DLY) ? MAX_A : GAP_DLY;
   localparam int DW      = $clog2(MAX_DLY + 1);
   localparam int QW      = (QDIV < 2) ? 1 : $clog2(QDIV);
   localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   generate
      if (QDIV < 2 || MAX_RETRY < 0 || RW < 1) begin : g_param_check
         $error("camera_i2c_cfg_ctrl: QDIV must be at least 2");
      end
   endgenerate

   typedef enum logic [3:0] {
      PWR_WAIT, BUS_CLR, LOAD, START, BYTE, STOP, GAP, RST_WAIT, DONE, ERR
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [DW-1:0] dly_cnt;
   logic [QW-1:0] qcnt;
   logic [1:0]    phase;
   logic [3:0]    bit_cnt;
   logic [1:0]    byte_cnt;
   logic [31:0]   shift;
   logic          sda_low;
   logic          q_tick;
   logic          bit_end;
   logic          last_idx;
   logic          idx_step;
   logic          idx_clear;
   logic          retry_step;
   logic          nack_stop;

   assign q_tick   = (qcnt == QW'(QDIV - 1));
   assign bit_end  = q_tick && (phase == 2'd3);
   assign last_idx = (reg_index == 9'(REG_NUM - 1));
   assign sda      = sda_low ? 1'b0 : 1'bz;

`ifdef CAM_CFG_ACK_CHECK_EN
   logic          nack;
   logic [RW-1:0] retry_cnt;
   assign nack_stop = nack;
`else
   assign nack_stop = 1'b0;
   assign cfg_err   = 1'b0;
`endif

   // State register; reset drops straight back to the power-up wait.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= PWR_WAIT;
      else            state <= next_state;
   end

   // Next-state logic, plus the index/retry bookkeeping strobes decided at the same point.
   always_comb begin
      next_state = state;
      idx_step   = 1'b0;
      idx_clear  = 1'b0;
      retry_step = 1'b0;
      case (state)
         PWR_WAIT: if (dly_cnt == DW'(PWR_DLY - 1)) next_state = BUS_CLR;
         BUS_CLR:  if (bit_end && bit_cnt == 4'd9) next_state = LOAD;
         LOAD:     next_state = START;
         START:    if (bit_end) next_state = BYTE;
         BYTE:     if (bit_end && bit_cnt == 4'd8 && (byte_cnt == 2'd3 || nack_stop))
                      next_state = STOP;
         STOP:     if (bit_end) next_state = GAP;
         GAP: begin
            if (dly_cnt == DW'(GAP_DLY - 1)) begin
`ifdef CAM_CFG_ACK_CHECK_EN
               if (nack) begin
                  if (retry_cnt == RW'(MAX_RETRY)) next_state = ERR;
                  else begin
                     next_state = LOAD;
                     retry_step = 1'b1;
                  end
               end else
`endif
               if (reg_index == 9'(SWRST_IDX)) next_state = RST_WAIT;
               else if (last_idx) next_state = DONE;
               else begin
                  next_state = LOAD;
                  idx_step   = 1'b1;
               end
            end
         end
         RST_WAIT: begin
            if (dly_cnt == DW'(SWRST_DLY - 1)) begin
               if (last_idx) next_state = DONE;
               else begin
                  next_state = LOAD;
                  idx_step   = 1'b1;
               end
            end
         end
         DONE, ERR: begin
            if (cfg_start) begin
               next_state = PWR_WAIT;
               idx_clear  = 1'b1;
            end
         end
         default: next_state = PWR_WAIT;
      endcase
   end

   // Bus waveform decoded from state and quarter-bit phase; idle and reset leave the bus released.
   always_comb begin
      scl     = 1'b1;
      sda_low = 1'b0;
      case (state)
         BUS_CLR: begin
            if (bit_cnt == 4'd9) begin
               scl     = (phase != 2'd0);
               sda_low = (phase != 2'd3);
            end else begin
               scl = (phase == 2'd1) || (phase == 2'd2);
            end
         end
         START: begin
            scl     = (phase != 2'd3);
            sda_low = phase[1];
         end
         BYTE: begin
            scl     = (phase == 2'd1) || (phase == 2'd2);
            sda_low = (bit_cnt != 4'd8) && !shift[31];
         end
         STOP: begin
            scl     = (phase != 2'd0);
            sda_low = (phase != 2'd3);
         end
         default: ;
      endcase
   end

   // Delay counter, quarter/bit/byte counters and the outgoing shift register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dly_cnt  <= '0;
         qcnt     <= '0;
         phase    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         shift    <= '0;
      end else if (next_state != state) begin
         dly_cnt  <= '0;
         qcnt     <= '0;
         phase    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         if (state == LOAD) shift <= {DEV_ADDR, 1'b0, lut_data};
      end else begin
         if (state inside {PWR_WAIT, GAP, RST_WAIT}) dly_cnt <= dly_cnt + DW'(1);
         if (state inside {BUS_CLR, START, BYTE, STOP}) begin
            if (q_tick) begin
               qcnt  <= '0;
               phase <= phase + 2'd1;
               if (phase == 2'd3) begin
                  if (state == BYTE && bit_cnt == 4'd8) begin
                     bit_cnt  <= '0;
                     byte_cnt <= byte_cnt + 2'd1;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     if (state == BYTE) shift <= {shift[30:0], 1'b0};
                  end
               end
            end else begin
               qcnt <= qcnt + QW'(1);
            end
         end
      end
   end

   // LUT index: steps after each completed register, never past the last entry.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)     reg_index <= '0;
      else if (idx_clear) reg_index <= '0;
      else if (idx_step)  reg_index <= reg_index + 9'd1;
   end

   // Status flags registered from the upcoming state so they read 0 while reset is held.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cfg_busy <= 1'b0;
         cfg_done <= 1'b0;
      end else begin
         cfg_busy <= !(next_state inside {DONE, ERR});
         cfg_done <= (next_state == DONE);
      end
   end

`ifdef CAM_CFG_ACK_CHECK_EN
   // ACK sampling in Q2 of the ninth bit, per-index retry count and the error flag.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         nack      <= 1'b0;
         retry_cnt <= '0;
         cfg_err   <= 1'b0;
      end else begin
         if (state == LOAD) nack <= 1'b0;
         else if (state == BYTE && bit_cnt == 4'd8 && phase == 2'd2 && q_tick) nack <= sda;
         if (idx_step || idx_clear) retry_cnt <= '0;
         else if (retry_step)       retry_cnt <= retry_cnt + RW'(1);
         cfg_err <= (next_state == ERR);
      end
   end
`endif

endmodule

// File: tb/tb_camera_i2c_cfg_ctrl.sv
// tb_camera_i2c_cfg_ctrl
// Directed bench: a bus monitor decodes START/STOP and bytes and acts as an ACKing slave;
// the main sequence walks reset, a full configuration pass, replay, NACK handling and
// asynchronous reset in the middle of a byte.
`timescale 1ns/1ps
module tb_camera_i2c_cfg_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_start;
   logic [23:0] lut_data;
   logic [8:0]  reg_index;
   logic        scl;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_err;
   wire         sda;
   logic        slave_low = 1'b0;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc;

   logic [7:0] rx_q[$];
   logic       ack_q[$];
   int         start_q[$];
   int         stop_q[$];
   int         rises_pre;
   int         rises_first;
   int         first_low;
   int         nack_left;
   int         fbytes;
   logic [7:0] fb1;
   bit         in_frame;
   int         nbits;
   bit         ack_phase;
   logic [7:0] sh;
   logic       p_scl;
   logic       p_sda;

   logic [7:0] exp_bytes [16] = '{8'hC0, 8'h01, 8'h00, 8'h00,
                                  8'hC0, 8'h01, 8'h03, 8'h01,
                                  8'hC0, 8'h00, 8'h00, 8'h00,
                                  8'hC0, 8'h30, 8'h06, 8'hA5};

   pullup (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   camera_i2c_cfg_ctrl #(
      .CLK_FREQ (8_000_000),
      .I2C_FREQ (1_000_000),
      .DEV_ADDR (7'h60),
      .REG_NUM  (4),
      .PWR_DLY  (100),
      .SWRST_DLY(50),
      .SWRST_IDX(1),
      .MAX_RETRY(3)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .cfg_start(cfg_start),
      .lut_data (lut_data),
      .reg_index(reg_index),
      .scl      (scl),
      .sda      (sda),
      .cfg_busy (cfg_busy),
      .cfg_done (cfg_done),
      .cfg_err  (cfg_err)
   );

   // Combinational register LUT model.
   always_comb begin
      lut_data = 24'h000000;
      case (reg_index)
         9'd0: lut_data = 24'h010000;
         9'd1: lut_data = 24'h010301;
         9'd2: lut_data = 24'h000000;
         9'd3: lut_data = 24'h3006A5;
         default: lut_data = 24'h000000;
      endcase
   end

   // Clock cycles since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Bus monitor and slave: decodes START/STOP/bytes and drives ACK unless a NACK is scheduled.
   always @(negedge clk) begin
      logic s;
      s = sda;
      if (!rst_n) begin
         in_frame  = 1'b0;
         nbits     = 0;
         ack_phase = 1'b0;
         slave_low = 1'b0;
         p_scl     = 1'b1;
         p_sda     = 1'b1;
         first_low = -1;
         rises_pre = 0;
         fbytes    = 0;
      end else begin
         if (p_scl && scl && p_sda && !s) begin
            if (start_q.size() == 0) rises_first = rises_pre;
            in_frame  = 1'b1;
            nbits     = 0;
            ack_phase = 1'b0;
            fbytes    = 0;
            start_q.push_back(cyc);
         end else if (p_scl && scl && !p_sda && s) begin
            in_frame  = 1'b0;
            slave_low = 1'b0;
            stop_q.push_back(cyc);
         end else if (!p_scl && scl) begin
            if (!in_frame) rises_pre++;
            else if (nbits < 8) begin
               sh = {sh[6:0], s};
               nbits++;
               if (nbits == 8) begin
                  rx_q.push_back(sh);
                  fbytes++;
                  if (fbytes == 2) fb1 = sh;
               end
            end else begin
               ack_q.push_back(s);
               ack_phase = 1'b1;
            end
         end else if (p_scl && !scl && in_frame) begin
            if (ack_phase) begin
               slave_low = 1'b0;
               ack_phase = 1'b0;
               nbits     = 0;
            end else if (nbits == 8) begin
               if (nack_left > 0 && fbytes == 3 && fb1 == 8'h00) begin
                  slave_low = 1'b0;
                  nack_left--;
               end else begin
                  slave_low = 1'b1;
               end
            end
         end
         if (first_low < 0 && !scl) first_low = cyc;
         p_scl = scl;
         p_sda = s;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One-cycle cfg_start pulse; returns 1 ns after the edge that sampled it.
   task automatic apply_stimulus();
      @(posedge clk);
      #1 cfg_start = 1'b1;
      @(posedge clk);
      #1 cfg_start = 1'b0;
   endtask

   task automatic wait_finish(input string tag);
      int i;
      for (i = 0; i < 6000 && !(cfg_done || cfg_err); i++) @(posedge clk);
      #2;
      check_output(tag, 32'(cfg_done || cfg_err), 32'd1);
   endtask

   task automatic clear_queues();
      rx_q.delete();
      ack_q.delete();
      start_q.delete();
      stop_q.delete();
   endtask

   initial begin
      int acks;
      cfg_start = 1'b0;
      nack_left = 0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      $display("[TB] reset state");
      check_output("rst_scl", 32'(scl), 32'd1);
      check_output("rst_sda", 32'(sda), 32'd1);
      check_output("rst_index", 32'(reg_index), 32'd0);
      check_output("rst_busy", 32'(cfg_busy), 32'd0);
      check_output("rst_done", 32'(cfg_done), 32'd0);
      check_output("rst_err", 32'(cfg_err), 32'd0);

      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      check_output("pwr_busy", 32'(cfg_busy), 32'd1);
      check_output("pwr_scl_idle", 32'(scl), 32'd1);

      // cfg_start during the first byte must be ignored
      for (int i = 0; i < 3000 && rx_q.size() < 1; i++) @(posedge clk);
      check_output("first_byte_seen", 32'(rx_q.size() >= 1), 32'd1);
      apply_stimulus();
      #1;
      check_output("midxfer_busy", 32'(cfg_busy), 32'd1);
      check_output("midxfer_done", 32'(cfg_done), 32'd0);
      check_output("midxfer_index", 32'(reg_index), 32'd0);

      wait_finish("run1_finish");
      $display("[TB] first pass complete");
      check_output("run1_done", 32'(cfg_done), 32'd1);
      check_output("run1_busy", 32'(cfg_busy), 32'd0);
      check_output("run1_err", 32'(cfg_err), 32'd0);
      check_output("run1_index", 32'(reg_index), 32'd3);
      check_output("run1_scl", 32'(scl), 32'd1);
      check_output("run1_sda", 32'(sda), 32'd1);
      check_output("pwr_dly_first_low", 32'(first_low), 32'd100);
      check_output("busclr_rises", 32'(rises_first), 32'd10);
      check_output("run1_starts", 32'(start_q.size()), 32'd4);
      check_output("run1_stops", 32'(stop_q.size()), 32'd5);
      check_output("run1_nbytes", 32'(rx_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < rx_q.size(); i++)
         check_output($sformatf("run1_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
      acks = 0;
      foreach (ack_q[i]) if (ack_q[i] !== 1'b0) acks++;
      check_output("run1_nacks", 32'(acks), 32'd0);
      if (start_q.size() >= 3 && stop_q.size() >= 3) begin
         check_output("swrst_extra_gap",
                      32'((start_q[2] - stop_q[2]) - (start_q[1] - stop_q[1])), 32'd50);
         check_output("swrst_gap_min", 32'((start_q[2] - stop_q[2]) >= 58), 32'd1);
      end

      // replay from DONE with a NACK on idx2 addr_lo
      clear_queues();
`ifdef CAM_CFG_ACK_CHECK_EN
      nack_left = 4;
`else
      nack_left = 1;
`endif
      apply_stimulus();
      #1;
      check_output("replay_done_clr", 32'(cfg_done), 32'd0);
      check_output("replay_index", 32'(reg_index), 32'd0);
      check_output("replay_busy", 32'(cfg_busy), 32'd1);
      wait_finish("run2_finish");
`ifdef CAM_CFG_ACK_CHECK_EN
      check_output("retry_err", 32'(cfg_err), 32'd1);
      check_output("retry_busy", 32'(cfg_busy), 32'd0);
      check_output("retry_done", 32'(cfg_done), 32'd0);
      check_output("retry_scl", 32'(scl), 32'd1);
      check_output("retry_sda", 32'(sda), 32'd1);
      check_output("retry_starts", 32'(start_q.size()), 32'd6);
      check_output("retry_nbytes", 32'(rx_q.size()), 32'd20);
      for (int i = 8; i < 20 && i < rx_q.size(); i++)
         check_output($sformatf("retry_byte%0d", i), 32'(rx_q[i]),
                      ((i - 8) % 3 == 0) ? 32'hC0 : 32'h00);
      clear_queues();
      nack_left = 0;
      apply_stimulus();
      #1;
      check_output("err_clear", 32'(cfg_err), 32'd0);
      check_output("err_restart_busy", 32'(cfg_busy), 32'd1);
`else
      check_output("run2_done", 32'(cfg_done), 32'd1);
      check_output("run2_err", 32'(cfg_err), 32'd0);
      check_output("run2_nbytes", 32'(rx_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < rx_q.size(); i++)
         check_output($sformatf("run2_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
      if (ack_q.size() >= 11) begin
         check_output("run2_ack9", 32'(ack_q[9]), 32'd0);
         check_output("run2_nack10", 32'(ack_q[10]), 32'd1);
      end
      clear_queues();
      nack_left = 0;
      apply_stimulus();
`endif

      // asynchronous reset in the middle of the idx1 device byte
      for (int i = 0; i < 3000 && !(start_q.size() >= 2 && in_frame && nbits == 3 && !scl); i++) begin
         @(posedge clk);
         #2;
      end
      check_output("midbyte_reached", 32'(start_q.size() >= 2 && in_frame && nbits == 3 && !scl), 32'd1);
      check_output("midbyte_sda_low", 32'(sda), 32'd0);
      check_output("midbyte_index", 32'(reg_index), 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("async_rst_scl", 32'(scl), 32'd1);
      check_output("async_rst_sda", 32'(sda), 32'd1);
      check_output("async_rst_index", 32'(reg_index), 32'd0);
      check_output("async_rst_busy", 32'(cfg_busy), 32'd0);
      @(posedge clk);
      @(posedge clk);
      clear_queues();
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3000 && rx_q.size() < 4; i++) @(posedge clk);
      check_output("restart_nbytes", 32'(rx_q.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < rx_q.size(); i++)
         check_output($sformatf("restart_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
      check_output("restart_first_low", 32'(first_low), 32'd100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
